pwm_led_ctrl: RTL and testbench



---
 rtl/pwm_led_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pwm_led_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_led_ctrl.sv
// Key-driven duty sequencer for the PWM LED path: debounced up/down stepping with
// auto-repeat in manual mode, and a two-key chord toggling a triangle "breathing" ramp.
module pwm_led_db #(
   parameter logic [15:0] DB_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db
);
   logic        s1, s2;
   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         db  <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == db) cnt <= '0;
         else if (cnt == DB_CYCLES - 16'd1) begin
            db  <= s2;
            cnt <= '0;
         end else cnt <= cnt + 16'd1;
      end
   end
endmodule

module pwm_led_ctrl #(
   parameter logic [15:0] DB_CYCLES     = 16'd50000,
   parameter logic [23:0] REPEAT_CYCLES = 24'd5000000,
   parameter logic [15:0] BREATHE_DIV   = 16'd4096,
   parameter logic [9:0]  STEP          = 10'd1,
   parameter logic [9:0]  DUTY_MAX      = 10'd1023,
   parameter logic [9:0]  DUTY_MIN      = 10'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key,
   output logic [9:0] duty,
   output logic       duty_stb,
   output logic       mode
);
   typedef enum logic [2:0] {MANUAL, HOLD, BR_UP, BR_DN, RELEASE} state_t;

   state_t      state, state_n;
   logic [1:0]  db, db_q;
   logic [23:0] rcnt, rcnt_n;
   logic [15:0] bcnt, bcnt_n;
   logic [9:0]  duty_n, up_val, dn_val;
   logic [10:0] up_sum, dn_diff;
   logic        dir, dir_n, mode_n;
   logic        up_rise, dn_rise, chord, rep_tick, br_tick;

   for (genvar i = 0; i < 2; i++) begin : g_db
      pwm_led_db #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk (clk),
         .rst (rst),
         .raw (key[i]),
         .db  (db[i])
      );
   end

   // 11-bit step arithmetic so the clamp sees overflow/underflow before truncation
   assign up_sum  = {1'b0, duty} + {1'b0, STEP};
   assign dn_diff = {1'b0, duty} - {1'b0, STEP};
   assign up_val  = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[9:0];
   assign dn_val  = (dn_diff[10] || dn_diff < {1'b0, DUTY_MIN}) ? DUTY_MIN : dn_diff[9:0];

   assign up_rise  = db[0] & ~db_q[0];
   assign dn_rise  = db[1] & ~db_q[1];
   assign chord    = (db == 2'b11) && (db_q != 2'b11);
   assign rep_tick = (rcnt == REPEAT_CYCLES - 24'd1);
   assign br_tick  = (bcnt == BREATHE_DIV - 16'd1);

   always_comb begin
      state_n = state;
      duty_n  = duty;
      mode_n  = mode;
      dir_n   = dir;
      rcnt_n  = rcnt;
      bcnt_n  = bcnt;
      case (state)
         MANUAL: begin
            if (chord) begin
               mode_n  = ~mode;
               state_n = RELEASE;
            end else if (up_rise && db == 2'b01) begin
               duty_n  = up_val;
               dir_n   = 1'b0;
               rcnt_n  = '0;
               state_n = HOLD;
            end else if (dn_rise && db == 2'b10) begin
               duty_n  = dn_val;
               dir_n   = 1'b1;
               rcnt_n  = '0;
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (chord) begin
               mode_n  = ~mode;
               state_n = RELEASE;
            end else if (db == 2'b00) begin
               state_n = MANUAL;
            end else if (db == 2'b01 && dir) begin
               duty_n = up_val;
               dir_n  = 1'b0;
               rcnt_n = '0;
            end else if (db == 2'b10 && !dir) begin
               duty_n = dn_val;
               dir_n  = 1'b1;
               rcnt_n = '0;
            end else if (rep_tick) begin
               duty_n = dir ? dn_val : up_val;
               rcnt_n = '0;
            end else rcnt_n = rcnt + 24'd1;
         end
         BR_UP: begin
            if (chord) begin
               mode_n  = 1'b0;
               bcnt_n  = '0;
               state_n = RELEASE;
            end else if (br_tick) begin
               bcnt_n = '0;
               duty_n = up_val;
               if (up_val == DUTY_MAX) state_n = BR_DN;
            end else bcnt_n = bcnt + 16'd1;
         end
         BR_DN: begin
            if (chord) begin
               mode_n  = 1'b0;
               bcnt_n  = '0;
               state_n = RELEASE;
            end else if (br_tick) begin
               bcnt_n = '0;
               duty_n = dn_val;
               if (dn_val == DUTY_MIN) state_n = BR_UP;
            end else bcnt_n = bcnt + 16'd1;
         end
         RELEASE: begin
            if (db == 2'b00) begin
               bcnt_n  = '0;
               state_n = mode ? BR_UP : MANUAL;
            end
         end
         default: state_n = MANUAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= MANUAL;
         duty     <= DUTY_MIN;
         duty_stb <= 1'b0;
         mode     <= 1'b0;
         dir      <= 1'b0;
         rcnt     <= '0;
         bcnt     <= '0;
         db_q     <= 2'b00;
      end else begin
         state    <= state_n;
         duty     <= duty_n;
         duty_stb <= (duty_n != duty);
         mode     <= mode_n;
         dir      <= dir_n;
         rcnt     <= rcnt_n;
         bcnt     <= bcnt_n;
         db_q     <= db;
      end
   end
endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Scoreboard bench for pwm_led_ctrl with short debounce/repeat/breathe intervals.
module tb_pwm_led_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key;
   logic [9:0] duty;
   logic       duty_stb;
   logic       mode;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];

   pwm_led_ctrl #(
      .DB_CYCLES    (16'd4),
      .REPEAT_CYCLES(24'd16),
      .BREATHE_DIV  (16'd8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key      (key),
      .duty     (duty),
      .duty_stb (duty_stb),
      .mode     (mode)
   );

   always #5 clk = ~clk;

   // every strobe must match the next queued duty value
   always @(negedge clk) begin : mon
      int e;
      if (duty_stb === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stb_unexpected: got duty=%0d, required no strobe", duty);
         end else begin
            e = exp_q.pop_front();
            if (int'(duty) != e) begin
               miscompares++;
               $display("FAIL stb_value: got duty=%0d, required %0d", duty, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      key = 2'b00;
      cyc(3);
      vectors++;
      if (duty !== 10'd0 || mode !== 1'b0 || duty_stb !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got duty=%0d mode=%b stb=%b, required 0/0/0", duty, mode, duty_stb);
      end
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_debounce;
      int lat = 0;
      key = 2'b01;
      cyc(3);
      key = 2'b00;
      cyc(12);
      vectors++;
      if (duty !== 10'd0) begin
         miscompares++;
         $display("FAIL glitch_duty: got %0d, required 0", duty);
      end
      exp_q.push_back(1);
      exp_q.push_back(2);
      key = 2'b01;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (duty_stb === 1'b1 && lat == 0) lat = i;
      end
      vectors++;
      if (lat != 7) begin
         miscompares++;
         $display("FAIL press_latency: got %0d cycles, required 7", lat);
      end
      repeat (9) @(negedge clk);
      key = 2'b00;
      cyc(15);
      vectors++;
      if (duty !== 10'd2 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL hold_repeat: got duty=%0d pending=%0d, required 2/0", duty, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_hold;
      for (int v = 3; v <= 37; v++) exp_q.push_back(v);
      key = 2'b01;
      for (int i = 0; i < 2000 && duty !== 10'd37; i++) @(negedge clk);
      vectors++;
      if (duty !== 10'd37) begin
         miscompares++;
         $display("FAIL reach_37: got %0d, required 37", duty);
      end
      rst = 1'b1;
      key = 2'b00;
      @(negedge clk);
      vectors++;
      if (duty !== 10'd0 || mode !== 1'b0 || duty_stb !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_hold: got duty=%0d mode=%b stb=%b, required 0/0/0", duty, mode, duty_stb);
      end
      rst = 1'b0;
      cyc(20);
      vectors++;
      if (duty !== 10'd0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL post_reset_idle: got duty=%0d pending=%0d, required 0/0", duty, exp_q.size());
      end
   endtask

   task automatic test_down_sat;
      key = 2'b10;
      cyc(10);
      vectors++;
      if (duty !== 10'd0) begin
         miscompares++;
         $display("FAIL down_sat: got %0d, required 0", duty);
      end
      exp_q.push_back(1);
      key = 2'b01;
      cyc(10);
      key = 2'b00;
      cyc(12);
      vectors++;
      if (duty !== 10'd1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL opposite_key: got duty=%0d pending=%0d, required 1/0", duty, exp_q.size());
      end
   endtask

   task automatic test_repeat_sat;
      for (int v = 2; v <= 1023; v++) exp_q.push_back(v);
      key = 2'b01;
      for (int i = 0; i < 17000 && duty !== 10'd1023; i++) @(negedge clk);
      vectors++;
      if (duty !== 10'd1023) begin
         miscompares++;
         $display("FAIL reach_max: got %0d, required 1023", duty);
      end
      cyc(100);
      key = 2'b00;
      cyc(12);
      vectors++;
      if (duty !== 10'd1023 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL up_sat: got duty=%0d pending=%0d, required 1023/0", duty, exp_q.size());
      end
   endtask

   task automatic test_breathing;
      int n = 0;
      int last = -1;
      int total;
      key = 2'b11;
      cyc(10);
      vectors++;
      if (mode !== 1'b1 || duty !== 10'd1023) begin
         miscompares++;
         $display("FAIL chord_enter: got mode=%b duty=%0d, required 1/1023", mode, duty);
      end
      cyc(20);
      for (int v = 1022; v >= 0; v--) exp_q.push_back(v);
      for (int v = 1; v <= 1023; v++) exp_q.push_back(v);
      for (int v = 1022; v >= 500; v--) exp_q.push_back(v);
      total = exp_q.size();
      key = 2'b00;
      for (int c = 0; c < 25000 && n < total; c++) begin
         @(negedge clk);
         if (duty_stb === 1'b1) begin
            n++;
            if (last >= 0) begin
               vectors++;
               if (c - last != 8) begin
                  miscompares++;
                  $display("FAIL breathe_period: got %0d cycles at duty=%0d, required 8", c - last, duty);
               end
            end
            last = c;
         end
      end
      vectors++;
      if (n != total || duty !== 10'd500) begin
         miscompares++;
         $display("FAIL breathe_reach_500: got %0d strobes duty=%0d, required %0d/500", n, duty, total);
      end
      key = 2'b11;
      cyc(10);
      vectors++;
      if (mode !== 1'b0 || duty !== 10'd500) begin
         miscompares++;
         $display("FAIL chord_exit: got mode=%b duty=%0d, required 0/500", mode, duty);
      end
      key = 2'b00;
      cyc(12);
      vectors++;
      if (mode !== 1'b0 || duty !== 10'd500) begin
         miscompares++;
         $display("FAIL frozen: got mode=%b duty=%0d, required 0/500", mode, duty);
      end
      exp_q.push_back(501);
      key = 2'b01;
      cyc(10);
      key = 2'b00;
      cyc(12);
      vectors++;
      if (duty !== 10'd501 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL manual_after_exit: got duty=%0d pending=%0d, required 501/0", duty, exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      key = 2'b00;
      test_reset;
      test_debounce;
      test_reset_mid_hold;
      test_down_sat;
      test_repeat_sat;
      test_breathing;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
